bit_serial_adder: RTL and testbench
===================================

# bit_serial_adder

Bit-serial, LSB-first word adder built around the single-bit full-adder cell. The block latches two W-bit operands and a carry-in, then drives the external full-adder cell one bit per clock (`fa_a`, `fa_b`, `fa_ci`). It consumes the cell's `fa_s`/`fa_co` each cycle, keeps the carry in a flop and shifts the sum bits into a result register. It is the sequencing stage directly around the full adder: it feeds all three of the cell's inputs and consumes both of its outputs.

## Interface
- `W`, default 8: operand/sum width in bits, legal range W ≥ 1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a_in`  in  W  operand A; captured on an accepted start.
- `b_in`  in  W  operand B; captured on an accepted start.
- `cin`  in  1  carry-in; captured on an accepted start.
- `fa_a`  out  1  to the cell's `a`.
- `fa_b`  out  1  to the cell's `b`.
- `fa_ci`  out  1  to the cell's `ci`.
- `fa_s`  in  1  from the cell's `s`; combinational, same cycle.
- `fa_co`  in  1  from the cell's `co`; combinational, same cycle.
- `busy`  out  1  high while bits are being processed (RUN).
- `done`  out  1  one-cycle pulse; `sum`/`cout` are valid from this cycle on.
- `sum`  out  W  result, A+B+cin mod 2^W.
- `cout`  out  1  carry out of bit W-1.

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: W cycles, one bit per cycle.
  - DONE: one cycle.
- IDLE, `start`=1 → capture `a_in`, `b_in` into shift registers, capture `cin` into the carry flop, clear the bit counter, go to RUN.
- RUN cycle k (k = 0..W-1), combinational drive:
  - `fa_a` = A_shift[0], `fa_b` = B_shift[0], `fa_ci` = carry.
- RUN cycle k, at the clock edge:
  - A_shift and B_shift shift right by one.
  - Sum shift register shifts right with `fa_s` entering at bit W-1.
  - carry ← `fa_co`; counter increments.
- After bit W-1 the sum register holds bits in correct order and carry holds the final carry.
  - Transfer both to `sum`/`cout`; go to DONE.
- DONE: `done`=1 for exactly one cycle.
  - `start`=1 here is accepted exactly as in IDLE and goes to RUN (back-to-back).
  - Otherwise go to IDLE.
- `start` during RUN is ignored; operands and the sequence are unaffected.
- `sum`/`cout` hold their last value until the next DONE. They do not change during RUN.
- `fa_a`, `fa_b`, `fa_ci` are 0 in IDLE and DONE.
- Bit counter width is max(1, $clog2(W)). The RUN→DONE transition occurs when counter == W-1.
- W=1: a single RUN cycle, then DONE.
- The block has no arithmetic of its own beyond the counter. All sum/carry logic comes from the external cell.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0; `fa_a`=`fa_b`=`fa_ci`=0; shift registers, carry and counter = 0.
- Reset asserted mid-RUN aborts immediately. No `done` is produced and `sum`/`cout` go to 0.
- Release is synchronous to the next rising edge.
- Latency, with `start` sampled high at edge E0:
  - `busy`=1 in cycles 1..W.
  - Bit k is driven in cycle 1+k.
  - `done`=1 and the new `sum`/`cout` appear in cycle W+1.
  - Total: W+1 cycles from start to done.
- Throughput with back-to-back starts (`start` held high in DONE): one result per W+1 cycles.
- `busy` and `done` are registered state decodes and are never high together.
- `fa_*` outputs are combinational from registers only; there is no path from `fa_s`/`fa_co` back to `fa_*`.

## Test plan
The bench instantiates the gate-level full-adder cell on the `fa_*` ports.
- W=8: start with A=0x5A, B=0x3C, cin=0 → `busy` high in cycles 1..8; `done` in cycle 9 with `sum`=0x96, `cout`=0.
- Wrap-around: A=0xFF, B=0x01, cin=0 → `sum`=0x00, `cout`=1. Then A=0xFF, B=0xFF, cin=1 → `sum`=0xFF, `cout`=1.
- `start` pulsed in cycle 4 of RUN with different operands → ignored. Result is still that of the first operands and `done` is still in cycle 9.
- Back-to-back: 0x01+0x02 with `start` held through DONE, followed by 0x80+0x80 → `done` in cycles 9 and 18 with `sum`=0x03/`cout`=0, then `sum`=0x00/`cout`=1.
- `rst_n` low during RUN cycle 3 → all outputs 0 immediately, no `done`. A subsequent 0x10+0x20 completes with `sum`=0x30.
- W=1 instance: A=1, B=1, cin=1 → `done` in cycle 2 with `sum`=1, `cout`=1.

Source files
------------

// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_adder
// Brief    : LSB-first bit-serial word adder that sequences an external
//            single-bit full-adder cell. It latches the operands and carry-in,
//            feeds the cell one bit per clock, and collects sum/carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_ci,
  input  logic         fa_s,
  input  logic         fa_co,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  // The counter is at least one bit wide so that W=1 still has a legal vector.
  localparam int            C_CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    s_sh_q, s_sh_d;
  logic            carry_q, carry_d;
  logic [C_CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  // Next-state and datapath: load on an accepted start, shift one bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          s_sh_d  = '0;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Shift-then-insert keeps this valid for W=1 without part-selects.
        a_sh_d         = a_sh_q >> 1;
        b_sh_d         = b_sh_q >> 1;
        s_sh_d         = s_sh_q >> 1;
        s_sh_d[W-1]    = fa_s;
        carry_d        = fa_co;
        cnt_d          = cnt_q + C_CW'(1);
        if (cnt_q == C_LAST) begin
          sum_d   = s_sh_d;
          cout_d  = fa_co;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Cell drive comes from registers only, gated to zero outside RUN.
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign fa_a  = busy & a_sh_q[0];
  assign fa_b  = busy & b_sh_q[0];
  assign fa_ci = busy & carry_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_adder
// Brief    : Directed, table-driven bench for bit_serial_adder (W=8 and W=1)
//            with a gate-level full-adder cell on the fa_* ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_adder;

  logic       clk;
  logic       rst_n;

  // W=8 instance signals
  logic       start;
  logic [7:0] a_in, b_in;
  logic       cin;
  logic       fa_a, fa_b, fa_ci, fa_s, fa_co;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout;

  // W=1 instance signals
  logic       start1;
  logic [0:0] a1, b1;
  logic       ci1;
  logic       fa_a1, fa_b1, fa_ci1, fa_s1, fa_co1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       cout1;

  int n_cmp = 0;
  int n_bad = 0;

  bit_serial_adder #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci), .fa_s(fa_s), .fa_co(fa_co),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  bit_serial_adder #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(ci1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_ci(fa_ci1), .fa_s(fa_s1), .fa_co(fa_co1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // Gate-level full-adder cells
  logic x8, g8, p8, x1, g1, p1;
  xor u_x8a (x8, fa_a, fa_b);
  xor u_x8b (fa_s, x8, fa_ci);
  and u_g8  (g8, fa_a, fa_b);
  and u_p8  (p8, x8, fa_ci);
  or  u_o8  (fa_co, g8, p8);
  xor u_x1a (x1, fa_a1, fa_b1);
  xor u_x1b (fa_s1, x1, fa_ci1);
  and u_g1  (g1, fa_a1, fa_b1);
  and u_p1  (p1, x1, fa_ci1);
  or  u_o1  (fa_co1, g1, p1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start high; return in cycle 1 of RUN with start low.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic ci);
    a_in  = a;
    b_in  = b;
    cin   = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in cycle 1 of RUN. Checks busy, per-bit drive and held sum through
  // cycles 1..8, then done/result in cycle 9. Returns in the DONE cycle.
  // glitch != 0: pulse start with other operands in that RUN cycle.
  task automatic run_check(input logic [7:0] a, input logic [7:0] b, input logic ci,
                           input logic [7:0] exp_s, input logic exp_co,
                           input logic [7:0] prev_s, input logic prev_co,
                           input int glitch);
    logic c;
    c = ci;
    for (int k = 0; k < 8; k++) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("done_run", {31'd0, done}, 32'd0);
      chk("fa_a", {31'd0, fa_a}, {31'd0, a[k]});
      chk("fa_b", {31'd0, fa_b}, {31'd0, b[k]});
      chk("fa_ci", {31'd0, fa_ci}, {31'd0, c});
      chk("sum_held", {23'd0, cout, sum}, {23'd0, prev_co, prev_s});
      c = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
      if (k + 1 == glitch) begin
        a_in  = 8'hE7;
        b_in  = 8'h3B;
        cin   = 1'b1;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("sum", {24'd0, sum}, {24'd0, exp_s});
    chk("cout", {31'd0, cout}, {31'd0, exp_co});
    chk("fa_done", {29'd0, fa_a, fa_b, fa_ci}, 32'd0);
  endtask

  task automatic idle_check(input logic [7:0] exp_s, input logic exp_co);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_fa", {29'd0, fa_a, fa_b, fa_ci}, 32'd0);
    chk("idle_sum", {23'd0, cout, sum}, {23'd0, exp_co, exp_s});
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [7:0] ps;
    logic       pc;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    tick();
    tick();
    // Reset state
    idle_check(8'h00, 1'b0);
    chk("rst_w1", {27'd0, busy1, done1, sum1, cout1, fa_a1 | fa_b1 | fa_ci1}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    idle_check(8'h00, 1'b0);

    // Table-driven operations
    ps = 8'h00; pc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].ci);
      run_check(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, ps, pc, 0);
      tick();
      idle_check(vecs[i].s, vecs[i].co);
      ps = vecs[i].s; pc = vecs[i].co;
    end

    // start pulsed in RUN cycle 4 is ignored
    launch(8'h5A, 8'h3C, 1'b0);
    run_check(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, ps, pc, 4);
    tick();
    idle_check(8'h96, 1'b0);

    // Back-to-back: start held through DONE
    launch(8'h01, 8'h02, 1'b0);
    run_check(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 8'h96, 1'b0, 0);
    launch(8'h80, 8'h80, 1'b0);
    run_check(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 0);
    tick();
    idle_check(8'h00, 1'b1);

    // Make sum nonzero so the reset clear is observable
    launch(8'hF0, 8'h0F, 1'b0);
    run_check(8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 0);
    tick();

    // Asynchronous reset in RUN cycle 3
    launch(8'h33, 8'h44, 1'b1);
    tick();
    tick();
    chk("busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    idle_check(8'h00, 1'b0);
    tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("no_done_after_rst", {30'd0, busy, done}, 32'd0);
    end
    launch(8'h10, 8'h20, 1'b0);
    run_check(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 8'h00, 1'b0, 0);
    tick();
    idle_check(8'h30, 1'b0);

    // W=1 instance: 1+1+1
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("w1_busy", {30'd0, busy1, done1}, 32'd2);
    chk("w1_fa", {29'd0, fa_a1, fa_b1, fa_ci1}, 32'd7);
    chk("w1_sum_held", {30'd0, sum1, cout1}, 32'd0);
    tick();
    chk("w1_done", {30'd0, busy1, done1}, 32'd1);
    chk("w1_result", {30'd0, sum1, cout1}, 32'd3);
    tick();
    chk("w1_idle", {28'd0, busy1, done1, sum1, cout1}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
